// File: rtl/pd2_pwr_responder.sv
// PD2 power responder: answers the PD0 controller's power-on / sleep handshake,
// sequencing staggered power-switch enables up and down around settle and drain phases.
module pd2_pwr_responder #(
    parameter int NUM_SW     = 4,
    parameter int SW_STEP    = 2,
    parameter int SETTLE_CYC = 3,
    parameter int DRAIN_TO   = 16
) (
    input  logic              i_aon_clk,
    input  logic              i_soc_pwr_on_rst,
    input  logic              i_pwr_on_req,
    input  logic              i_hw_sleep_req,
    input  logic              i_idle_ack,
    output logic              o_pwr_on_ack,
    output logic              o_hw_sleep_ack,
    output logic [NUM_SW-1:0] o_sw_en,
    output logic              o_idle_req,
    output logic              o_drain_timeout,
    output logic [2:0]        o_state
);

    localparam int MAX_A = (SW_STEP > SETTLE_CYC) ? SW_STEP : SETTLE_CYC;
    localparam int MAX_C = (MAX_A > DRAIN_TO) ? MAX_A : DRAIN_TO;
    localparam int CW    = $clog2(MAX_C) + 1;

    localparam logic [CW-1:0] STEP_LAST   = CW'(SW_STEP - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] DRAIN_LAST  = CW'(DRAIN_TO - 1);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);

    typedef enum logic [2:0] {
        S_OFF     = 3'd0,
        S_RAMP_UP = 3'd1,
        S_SETTLE  = 3'd2,
        S_ON_HS   = 3'd3,
        S_RUN     = 3'd4,
        S_DRAIN   = 3'd5,
        S_RAMP_DN = 3'd6,
        S_OFF_HS  = 3'd7
    } state_t;

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic [NUM_SW-1:0] r_sw_en;
    logic              r_drain_timeout;
    logic [NUM_SW-1:0] w_sw_up;
    logic [NUM_SW-1:0] w_sw_dn;

    // Thermometer neighbours: one more segment on, or the topmost segment off.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SW; gi++) begin : g_shift
            if (gi == 0) begin : g_lo
                assign w_sw_up[gi] = 1'b1;
            end else begin : g_up
                assign w_sw_up[gi] = r_sw_en[gi-1];
            end
            if (gi == NUM_SW - 1) begin : g_hi
                assign w_sw_dn[gi] = 1'b0;
            end else begin : g_dn
                assign w_sw_dn[gi] = r_sw_en[gi+1];
            end
        end
    endgenerate

    always_ff @(posedge i_aon_clk) begin
        if (i_soc_pwr_on_rst) begin
            r_state         <= S_OFF;
            r_cnt           <= '0;
            r_sw_en         <= '0;
            r_drain_timeout <= 1'b0;
        end else begin
            case (r_state)
                S_OFF: begin
                    if (i_pwr_on_req) begin
                        r_state         <= S_RAMP_UP;
                        r_sw_en         <= NUM_SW'(1);
                        r_cnt           <= '0;
                        r_drain_timeout <= 1'b0;
                    end
                end
                S_RAMP_UP: begin
                    // A withdrawn request aborts ahead of any step decision.
                    if (!i_pwr_on_req) begin
                        r_state <= S_RAMP_DN;
                        r_sw_en <= w_sw_dn;
                        r_cnt   <= '0;
                    end else if (r_cnt == STEP_LAST) begin
                        r_cnt <= '0;
                        if (&r_sw_en) begin
                            r_state <= S_SETTLE;
                        end else begin
                            r_sw_en <= w_sw_up;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                S_SETTLE: begin
                    if (!i_pwr_on_req) begin
                        r_state <= S_RAMP_DN;
                        r_sw_en <= w_sw_dn;
                        r_cnt   <= '0;
                    end else if (r_cnt == SETTLE_LAST) begin
                        r_state <= S_ON_HS;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                S_ON_HS: begin
                    if (!i_pwr_on_req) begin
                        r_state <= S_RAMP_DN;
                        r_sw_en <= w_sw_dn;
                        r_cnt   <= '0;
                    end else if (!i_hw_sleep_req) begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (i_hw_sleep_req || !i_pwr_on_req) begin
                        r_state <= S_DRAIN;
                        r_cnt   <= '0;
                    end
                end
                S_DRAIN: begin
                    // An ack arriving on the terminal cycle is a clean drain, not a timeout.
                    if (i_idle_ack) begin
                        r_state <= S_RAMP_DN;
                        r_sw_en <= w_sw_dn;
                        r_cnt   <= '0;
                    end else if (r_cnt == DRAIN_LAST) begin
                        r_state         <= S_RAMP_DN;
                        r_sw_en         <= w_sw_dn;
                        r_cnt           <= '0;
                        r_drain_timeout <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                S_RAMP_DN: begin
                    if (r_cnt == STEP_LAST) begin
                        r_cnt <= '0;
                        if (r_sw_en == '0) begin
                            r_state <= S_OFF_HS;
                        end else begin
                            r_sw_en <= w_sw_dn;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                S_OFF_HS: begin
                    // Hold here until the controller drops its stale power-on request.
                    if (!i_pwr_on_req) begin
                        r_state <= S_OFF;
                    end
                end
                default: begin
                    r_state <= S_OFF;
                    r_sw_en <= '0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign o_pwr_on_ack    = (r_state == S_ON_HS) || (r_state == S_RUN) || (r_state == S_DRAIN);
    assign o_hw_sleep_ack  = !((r_state == S_RUN) || (r_state == S_DRAIN));
    assign o_idle_req      = (r_state == S_DRAIN);
    assign o_sw_en         = r_sw_en;
    assign o_drain_timeout = r_drain_timeout;
    assign o_state         = r_state;

endmodule

// File: tb/tb_pd2_pwr_responder.sv
// Bench for pd2_pwr_responder: scenario tasks with randomized timing, checked against
// expected values derived arithmetically from the switch-step, settle and drain rules.
module tb_pd2_pwr_responder;

    localparam int NUM_SW     = 4;
    localparam int SW_STEP    = 2;
    localparam int SETTLE_CYC = 3;
    localparam int DRAIN_TO   = 16;
    localparam int RAMP_LEN   = NUM_SW * SW_STEP;
    localparam int UP_TOTAL   = RAMP_LEN + SETTLE_CYC;

    logic              clk = 1'b0;
    logic              rst;
    logic              req;
    logic              sleep;
    logic              idle;
    logic              pwr_ack;
    logic              sleep_ack;
    logic [NUM_SW-1:0] sw_en;
    logic              idle_req;
    logic              drain_to;
    logic [2:0]        state;

    int n_chk = 0;
    int n_err = 0;
    bit exp_to;

    pd2_pwr_responder #(
        .NUM_SW(NUM_SW), .SW_STEP(SW_STEP), .SETTLE_CYC(SETTLE_CYC), .DRAIN_TO(DRAIN_TO)
    ) dut (
        .i_aon_clk(clk),
        .i_soc_pwr_on_rst(rst),
        .i_pwr_on_req(req),
        .i_hw_sleep_req(sleep),
        .i_idle_ack(idle),
        .o_pwr_on_ack(pwr_ack),
        .o_hw_sleep_ack(sleep_ack),
        .o_sw_en(sw_en),
        .o_idle_req(idle_req),
        .o_drain_timeout(drain_to),
        .o_state(state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NUM_SW-1:0] thermo(input int k);
        logic [NUM_SW-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_SW; i++) if (i < k) v[i] = 1'b1;
        return v;
    endfunction

    function automatic int up_ones(input int t);
        int n;
        n = t / SW_STEP + 1;
        return (n > NUM_SW) ? NUM_SW : n;
    endfunction

    task automatic test_reset();
        rst = 1'b1; req = 1'b0; sleep = 1'b1; idle = 1'b0;
        tick(); tick();
        exp_to = 1'b0;
        n_chk++; if (state !== 3'd0) begin n_err++; $display("FAIL reset_state got=%0d exp=0", state); end
        n_chk++; if (sw_en !== '0) begin n_err++; $display("FAIL reset_sw got=%b exp=0", sw_en); end
        n_chk++; if (pwr_ack !== 1'b0 || sleep_ack !== 1'b1 || idle_req !== 1'b0 || drain_to !== 1'b0) begin
            n_err++; $display("FAIL reset_outs got pa=%b sa=%b ir=%b to=%b exp 0 1 0 0", pwr_ack, sleep_ack, idle_req, drain_to);
        end
        rst = 1'b0;
        tick();
        n_chk++; if (state !== 3'd0 || sw_en !== '0) begin n_err++; $display("FAIL idle_off got st=%0d sw=%b exp 0 0", state, sw_en); end
        $display("reset checked");
    endtask

    // From OFF: raise the request and follow the ramp up to t_last cycles after E0.
    task automatic power_up(input int t_last);
        logic [2:0] es;
        req = 1'b1; sleep = 1'b1;
        tick();
        exp_to = 1'b0;
        for (int t = 0; t <= t_last; t++) begin
            if (t > 0) tick();
            es = (t < RAMP_LEN) ? 3'd1 : ((t < UP_TOTAL) ? 3'd2 : 3'd3);
            n_chk++; if (sw_en !== thermo(up_ones(t))) begin n_err++; $display("FAIL up_sw t=%0d got=%b exp=%b", t, sw_en, thermo(up_ones(t))); end
            n_chk++; if (state !== es) begin n_err++; $display("FAIL up_state t=%0d got=%0d exp=%0d", t, state, es); end
            n_chk++; if (pwr_ack !== (t >= UP_TOTAL) || sleep_ack !== 1'b1) begin
                n_err++; $display("FAIL up_acks t=%0d got pa=%b sa=%b exp pa=%b sa=1", t, pwr_ack, sleep_ack, t >= UP_TOTAL);
            end
            if (t == 0) begin
                n_chk++; if (drain_to !== 1'b0) begin n_err++; $display("FAIL to_clear got=%b exp=0", drain_to); end
            end
        end
    endtask

    // Called just after the edge that entered RAMP_DN with n0 segments previously on.
    task automatic ramp_down(input int n0);
        int ones;
        logic [2:0] es;
        for (int t = 0; t <= n0 * SW_STEP; t++) begin
            if (t > 0) tick();
            ones = n0 - 1 - t / SW_STEP;
            if (ones < 0) ones = 0;
            es = (t < n0 * SW_STEP) ? 3'd6 : 3'd7;
            n_chk++; if (sw_en !== thermo(ones)) begin n_err++; $display("FAIL dn_sw t=%0d got=%b exp=%b", t, sw_en, thermo(ones)); end
            n_chk++; if (state !== es) begin n_err++; $display("FAIL dn_state t=%0d got=%0d exp=%0d", t, state, es); end
            n_chk++; if (pwr_ack !== 1'b0 || sleep_ack !== 1'b1 || idle_req !== 1'b0) begin
                n_err++; $display("FAIL dn_outs t=%0d got pa=%b sa=%b ir=%b exp 0 1 0", t, pwr_ack, sleep_ack, idle_req);
            end
        end
    endtask

    task automatic off_hs(input int hold);
        for (int i = 0; i < hold; i++) begin
            tick();
            n_chk++; if (state !== 3'd7 || sw_en !== '0) begin n_err++; $display("FAIL offhs_hold i=%0d got st=%0d sw=%b exp 7 0", i, state, sw_en); end
        end
        req = 1'b0;
        tick();
        n_chk++; if (state !== 3'd0 || sleep_ack !== 1'b1 || pwr_ack !== 1'b0) begin
            n_err++; $display("FAIL off_ret got st=%0d sa=%b pa=%b exp 0 1 0", state, sleep_ack, pwr_ack);
        end
        n_chk++; if (drain_to !== exp_to) begin n_err++; $display("FAIL to_sticky got=%b exp=%b", drain_to, exp_to); end
    endtask

    task automatic run_phase(input int on_wait, input int run_cyc, input bit by_sleep);
        for (int i = 0; i < on_wait; i++) begin
            tick();
            n_chk++; if (state !== 3'd3 || pwr_ack !== 1'b1) begin n_err++; $display("FAIL onhs_wait got st=%0d pa=%b exp 3 1", state, pwr_ack); end
        end
        sleep = 1'b0;
        tick();
        n_chk++; if (state !== 3'd4 || sleep_ack !== 1'b0 || pwr_ack !== 1'b1) begin
            n_err++; $display("FAIL run_entry got st=%0d sa=%b pa=%b exp 4 0 1", state, sleep_ack, pwr_ack);
        end
        for (int i = 0; i < run_cyc; i++) begin
            tick();
            n_chk++; if (state !== 3'd4) begin n_err++; $display("FAIL run_hold got=%0d exp=4", state); end
        end
        if (by_sleep) sleep = 1'b1; else req = 1'b0;
        tick();
        n_chk++; if (state !== 3'd5 || idle_req !== 1'b1 || pwr_ack !== 1'b1 || sleep_ack !== 1'b0) begin
            n_err++; $display("FAIL drain_entry got st=%0d ir=%b pa=%b sa=%b exp 5 1 1 0", state, idle_req, pwr_ack, sleep_ack);
        end
    endtask

    // idle_ack pulsed so it is sampled on the k-th edge after DRAIN entry.
    task automatic drain(input int k);
        bit ack;
        for (int e = 1; e <= DRAIN_TO; e++) begin
            idle = (e == k);
            tick();
            ack = (e == k);
            if (ack || e == DRAIN_TO) begin
                if (!ack) exp_to = 1'b1;
                n_chk++; if (state !== 3'd6) begin n_err++; $display("FAIL drain_exit e=%0d got=%0d exp=6", e, state); end
                n_chk++; if (drain_to !== exp_to) begin n_err++; $display("FAIL drain_to e=%0d got=%b exp=%b", e, drain_to, exp_to); end
                idle = 1'b0;
                break;
            end else begin
                n_chk++; if (state !== 3'd5 || idle_req !== 1'b1) begin n_err++; $display("FAIL drain_wait e=%0d got st=%0d ir=%b exp 5 1", e, state, idle_req); end
            end
        end
    endtask

    task automatic test_session(input int k, input bit by_sleep, input int on_wait, input int run_cyc, input int hold);
        power_up(UP_TOTAL);
        run_phase(on_wait, run_cyc, by_sleep);
        drain(k);
        ramp_down(NUM_SW);
        off_hs(by_sleep ? hold : 0);
        $display("session k=%0d sleep=%0d wait=%0d run=%0d hold=%0d timeout=%0d", k, by_sleep, on_wait, run_cyc, hold, exp_to);
    endtask

    task automatic test_abort(input int a);
        power_up(a);
        req = 1'b0;
        tick();
        ramp_down(up_ones(a));
        off_hs(0);
        $display("abort at t=%0d segments=%0d", a, up_ones(a));
    endtask

    task automatic test_reset_mid();
        power_up(3);
        rst = 1'b1;
        tick();
        exp_to = 1'b0;
        n_chk++; if (state !== 3'd0 || sw_en !== '0) begin n_err++; $display("FAIL midrst got st=%0d sw=%b exp 0 0", state, sw_en); end
        n_chk++; if (pwr_ack !== 1'b0 || sleep_ack !== 1'b1 || idle_req !== 1'b0 || drain_to !== 1'b0) begin
            n_err++; $display("FAIL midrst_outs got pa=%b sa=%b ir=%b to=%b exp 0 1 0 0", pwr_ack, sleep_ack, idle_req, drain_to);
        end
        req = 1'b0;
        rst = 1'b0;
        tick();
        n_chk++; if (state !== 3'd0) begin n_err++; $display("FAIL midrst_off got=%0d exp=0", state); end
        $display("reset mid ramp checked");
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; sleep = 1'b1; idle = 1'b0;
        test_reset();
        test_session(5, 1'b1, 2, 3, 3);
        test_session(DRAIN_TO + 1, 1'b1, 0, 1, 1);
        test_session(DRAIN_TO, 1'b1, 1, 0, 0);
        test_abort(2);
        test_abort(UP_TOTAL);
        test_reset_mid();
        for (int s = 0; s < 6; s++) begin
            test_session($urandom_range(1, DRAIN_TO + 4), 1'($urandom_range(0, 1)),
                         $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 3));
        end
        for (int s = 0; s < 5; s++) test_abort($urandom_range(0, UP_TOTAL));
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
